// File: rtl/lane_dispatch_pkg.sv
// Shared types and defaults for the lane dispatcher and its picker.
package lane_dispatch_pkg;
  localparam int LANES_DEFAULT   = 4;
  localparam int WIDTH_DEFAULT   = 8;
  localparam int CREDITS_DEFAULT = 4;

  typedef logic [$clog2(LANES_DEFAULT)-1:0]     lane_idx_t;
  typedef logic [$clog2(CREDITS_DEFAULT+1)-1:0] credit_t;
endpackage

// File: rtl/lane_dispatcher_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after start, wrapping.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);
  localparam int LW = $clog2(N);

  always_comb begin
    int j;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = LW'(j);
      end
    end
  end
endmodule

// File: rtl/lane_dispatcher.sv
// Credit-based lane dispatcher. Define LANE_DISPATCH_RR_EN for round-robin
// lane selection; otherwise the lowest-index lane with credit wins.
module lane_dispatcher
  import lane_dispatch_pkg::*;
#(
  parameter int N       = LANES_DEFAULT,
  parameter int M       = WIDTH_DEFAULT,
  parameter int CREDITS = CREDITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [M-1:0]         in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [M-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_sel,
  output logic                 out_valid,
  input  logic [N-1:0]         credit_ret,
  output logic                 credit_err
);
  localparam int LW = $clog2(N);
  localparam int CW = $clog2(CREDITS + 1);

  logic [CW-1:0] credit_reg [N];
  logic [N-1:0]  req;
  logic [N-1:0]  dec;
  logic [N-1:0]  over;
  logic [LW-1:0] start_ptr;
  logic [LW-1:0] pick_idx;
  logic          pick_found;
  logic          accept;

  logic [M-1:0]  out_data_reg;
  logic [LW-1:0] out_sel_reg;
  logic          out_valid_reg;
  logic          credit_err_reg;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .start (start_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign in_ready = |req;
  assign accept   = in_valid && pick_found;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign req[gi]  = (credit_reg[gi] != '0);
      assign dec[gi]  = accept && (pick_idx == LW'(gi));
      // A return with a same-cycle dispatch nets out, so only a lone return can overflow.
      assign over[gi] = credit_ret[gi] && !dec[gi] && (credit_reg[gi] == CW'(CREDITS));

      always_ff @(posedge clk) begin
        if (rst) begin
          credit_reg[gi] <= CW'(CREDITS);
        end else if (credit_ret[gi] && !dec[gi] && !over[gi]) begin
          credit_reg[gi] <= credit_reg[gi] + 1'b1;
        end else if (dec[gi] && !credit_ret[gi]) begin
          credit_reg[gi] <= credit_reg[gi] - 1'b1;
        end
      end
    end
  endgenerate

`ifdef LANE_DISPATCH_RR_EN
  logic [LW-1:0] ptr_reg;
  assign start_ptr = ptr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (accept) begin
      ptr_reg <= (pick_idx == LW'(N - 1)) ? '0 : pick_idx + 1'b1;
    end
  end
`else
  assign start_ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg   <= '0;
      out_sel_reg    <= '0;
      out_valid_reg  <= 1'b0;
      credit_err_reg <= 1'b0;
    end else begin
      out_valid_reg <= accept;
      if (accept) begin
        out_data_reg <= in_data;
        out_sel_reg  <= pick_idx;
      end
      if (|over) credit_err_reg <= 1'b1;
    end
  end

  assign out_data   = out_data_reg;
  assign out_sel    = out_sel_reg;
  assign out_valid  = out_valid_reg;
  assign credit_err = credit_err_reg;
endmodule

// File: tb/tb_lane_dispatcher.sv
// Directed and randomized checks of lane_dispatcher against a credit/lane reference model.
module tb_lane_dispatcher;
  localparam int N = 4;
  localparam int M = 8;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [M-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_valid;
  logic [N-1:0] credit_ret;
  logic         credit_err;

  lane_dispatcher #(.N(N), .M(M), .CREDITS(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .out_valid  (out_valid),
    .credit_ret (credit_ret),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  // Reference model: free slots per lane, next-search lane, expected outputs.
  int          cred [N];
  int          mptr;
  bit          merr;
  bit          exp_valid;
  logic [M-1:0] exp_data;
  int          exp_sel;
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) cred[i] = C;
    mptr = 0; merr = 0; exp_valid = 0; exp_data = '0; exp_sel = 0;
  endfunction

  function automatic int model_pick();
    for (int k = 0; k < N; k++) begin
      int j;
`ifdef LANE_DISPATCH_RR_EN
      j = (mptr + k) % N;
`else
      j = k;
`endif
      if (cred[j] > 0) return j;
    end
    return -1;
  endfunction

  task automatic step(input bit r, input bit v, input logic [M-1:0] d, input logic [N-1:0] ret);
    int  lane;
    bit  acc;
    bit  any;
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; credit_ret = ret;
    #1;
    any = 0;
    for (int i = 0; i < N; i++) if (cred[i] > 0) any = 1;
    check("in_ready", 32'(in_ready), 32'(any));
    if (r) begin
      model_reset();
    end else begin
      lane = model_pick();
      acc  = v && (lane >= 0);
      for (int i = 0; i < N; i++) begin
        if (ret[i] && !(acc && lane == i)) begin
          if (cred[i] == C) merr = 1;
          else cred[i]++;
        end
      end
      exp_valid = acc;
      if (acc) begin
        if (!ret[lane]) cred[lane]--;
        exp_data = d;
        exp_sel  = lane;
        mptr     = (lane + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d rst=%0b v=%0b d=%02h ret=%04b -> ovalid=%0b sel=%0d data=%02h err=%0b",
             cyc, r, v, d, ret, out_valid, out_sel, out_data, credit_err);
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("out_sel", 32'(out_sel), 32'(exp_sel));
    check("out_data", 32'(out_data), 32'(exp_data));
    check("credit_err", 32'(credit_err), 32'(merr));
  endtask

  initial begin
    logic [N-1:0] r;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; credit_ret = '0;
    model_reset();

    // Reset state
    step(1, 0, 8'h00, 4'b0000);
    step(0, 0, 8'h00, 4'b0000);

    // Back-to-back words drain all credits, then the 17th is refused
    for (int i = 0; i < 16; i++) step(0, 1, 8'(8'h10 + i), 4'b0000);
    step(0, 1, 8'h55, 4'b0000);

    // Single return from an empty state goes to lane 2
    step(0, 0, 8'h00, 4'b0100);
    step(0, 1, 8'h66, 4'b0000);
    step(0, 1, 8'h67, 4'b0000);

    // Refill lanes 0,2,3 only; lane 1 must be skipped
    for (int i = 0; i < C; i++) step(0, 0, 8'h00, 4'b1101);
    step(0, 1, 8'h20, 4'b0000);
    step(0, 1, 8'h21, 4'b0000);
    step(0, 1, 8'h22, 4'b0000);

    // Same-cycle accept and return on lane 0
    step(1, 0, 8'h00, 4'b0000);
    step(0, 1, 8'h30, 4'b0001);
    for (int i = 0; i < 2 * N * C; i++) step(0, 1, 8'(8'h40 + i), 4'b0000);

    // Return at full credit sets the sticky error; reset mid-stream clears all
    step(1, 0, 8'h00, 4'b0000);
    step(0, 0, 8'h00, 4'b1000);
    step(0, 1, 8'h50, 4'b0000);
    step(0, 1, 8'h51, 4'b0000);
    step(1, 1, 8'h52, 4'b0000);
    step(0, 1, 8'h53, 4'b0000);

    // Randomized traffic with occasional returns and resets
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 40) == 0) r[$urandom_range(0, N - 1)] = 1'b1;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 8'($urandom), r);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
